// File: rtl/fft_frame_arbiter.sv
// Round-robin frame arbiter sharing one pipelined FFT core between N_CH streams; tags each frame with its channel.
// Optional per-channel completed-frame counters when FFT_ARB_STATS_EN is defined.
module fft_frame_arbiter #(
    parameter int IN_W    = 20,
    parameter int FFT_LEN = 256,
    parameter int N_CH    = 4,
    parameter int TAG_D   = 4,
    localparam int CW     = $clog2(N_CH)
) (
    input  logic                 clk,
    input  logic                 i_rst_n,
    input  logic                 i_init,
    input  logic [N_CH-1:0]      i_req_vld,
    input  logic [N_CH*IN_W-1:0] i_req_I,
    input  logic [N_CH*IN_W-1:0] i_req_Q,
    output logic [N_CH-1:0]      o_req_rdy,
    output logic                 o_fft_init,
    output logic                 o_fft_vld,
    output logic [IN_W-1:0]      o_fft_I,
    output logic [IN_W-1:0]      o_fft_Q,
    input  logic                 i_fft_vld,
    input  logic                 i_fft_new_fft,
    output logic [CW-1:0]        o_ch_id,
    output logic                 o_tag_vld,
    output logic                 o_busy,
    output logic                 o_tag_err_strb
`ifdef FFT_ARB_STATS_EN
    ,output logic [N_CH*16-1:0]  o_frame_cnt
`endif
);

    localparam int CNTW = $clog2(FFT_LEN);
    localparam int PW   = $clog2(TAG_D);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t            state;
    logic [CW-1:0]     grant;
    logic [CW-1:0]     last_grant;
    logic [CNTW-1:0]   count;
    logic [CW-1:0]     tag_mem [TAG_D];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       occ;

    logic [CW-1:0]     pick;
    logic              pick_vld;
    int                idx;
    logic              full, empty, push, pop, hs, last_beat;

    // Round-robin scan starting just after the last completed grant.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!pick_vld && i_req_vld[idx[CW-1:0]]) begin
                pick     = idx[CW-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    // Handshake: a beat moves on any cycle where i_req_vld[c] and o_req_rdy[c] are both high;
    // ready is raised only for the granted channel while streaming and never waits on valid.
    always_comb begin
        o_req_rdy = '0;
        if (state == STREAM && !i_init) o_req_rdy[grant] = 1'b1;
    end

    assign hs        = |(i_req_vld & o_req_rdy);
    assign last_beat = hs && (count == CNTW'(FFT_LEN - 1));
    assign full      = (occ == (PW+1)'(TAG_D));
    assign empty     = (occ == '0);
    assign push      = (state == IDLE) && !full && pick_vld;
    assign pop       = i_fft_vld && i_fft_new_fft && !empty;
    assign o_busy    = (state == STREAM);

    always_ff @(posedge clk) begin
        if (push && !i_init) tag_mem[wr_ptr] <= pick;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            grant          <= '0;
            last_grant     <= CW'(N_CH - 1);
            count          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            occ            <= '0;
            o_fft_init     <= 1'b1;
            o_fft_vld      <= 1'b0;
            o_fft_I        <= '0;
            o_fft_Q        <= '0;
            o_ch_id        <= '0;
            o_tag_vld      <= 1'b0;
            o_tag_err_strb <= 1'b0;
        end else begin
            o_fft_init <= i_init;
            if (i_init) begin
                // Abandon any partial frame and its tag; last grant restarts the rotation.
                state          <= IDLE;
                grant          <= '0;
                last_grant     <= CW'(N_CH - 1);
                count          <= '0;
                wr_ptr         <= '0;
                rd_ptr         <= '0;
                occ            <= '0;
                o_fft_vld      <= 1'b0;
                o_fft_I        <= '0;
                o_fft_Q        <= '0;
                o_ch_id        <= '0;
                o_tag_vld      <= 1'b0;
                o_tag_err_strb <= 1'b0;
            end else begin
                o_fft_vld <= hs;
                if (hs) begin
                    o_fft_I <= i_req_I[int'(grant)*IN_W +: IN_W];
                    o_fft_Q <= i_req_Q[int'(grant)*IN_W +: IN_W];
                end
                case (state)
                    IDLE: begin
                        if (push) begin
                            grant <= pick;
                            state <= STREAM;
                        end
                    end
                    STREAM: begin
                        if (last_beat) begin
                            count      <= '0;
                            last_grant <= grant;
                            state      <= IDLE;
                        end else if (hs) begin
                            count <= count + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) begin
                    o_ch_id   <= tag_mem[rd_ptr];
                    o_tag_vld <= 1'b1;
                    rd_ptr    <= rd_ptr + 1'b1;
                end
                o_tag_err_strb <= i_fft_vld && i_fft_new_fft && empty;
                case ({push, pop})
                    2'b10:   occ <= occ + 1'b1;
                    2'b01:   occ <= occ - 1'b1;
                    default: occ <= occ;
                endcase
            end
        end
    end

`ifdef FFT_ARB_STATS_EN
    logic [15:0] frame_cnt [N_CH];

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int c = 0; c < N_CH; c++) frame_cnt[c] <= '0;
        end else if (i_init) begin
            for (int c = 0; c < N_CH; c++) frame_cnt[c] <= '0;
        end else if (last_beat && frame_cnt[grant] != 16'hFFFF) begin
            frame_cnt[grant] <= frame_cnt[grant] + 16'd1;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_cnt
        assign o_frame_cnt[c*16 +: 16] = frame_cnt[c];
    end
`endif

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Scoreboard bench for fft_frame_arbiter: random multi-channel traffic against a frame-level model,
// plus directed reset, tag underflow, abort and FIFO-full scenarios.
module tb_fft_frame_arbiter;

    localparam int IN_W    = 20;
    localparam int FFT_LEN = 8;
    localparam int N_CH    = 4;
    localparam int TAG_D   = 2;
    localparam int CW      = $clog2(N_CH);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 init = 1'b0;
    logic [N_CH-1:0]      req_vld = '0;
    logic [N_CH*IN_W-1:0] req_I = '0;
    logic [N_CH*IN_W-1:0] req_Q = '0;
    logic [N_CH-1:0]      req_rdy;
    logic                 fft_init, fft_vld_o;
    logic [IN_W-1:0]      fft_I, fft_Q;
    logic                 core_vld = 1'b0;
    logic                 core_new = 1'b0;
    logic [CW-1:0]        ch_id;
    logic                 tag_vld, busy, tag_err;
`ifdef FFT_ARB_STATS_EN
    logic [N_CH*16-1:0]   frame_cnt;
`endif

    fft_frame_arbiter #(.IN_W(IN_W), .FFT_LEN(FFT_LEN), .N_CH(N_CH), .TAG_D(TAG_D)) dut (
        .clk(clk), .i_rst_n(rst_n), .i_init(init),
        .i_req_vld(req_vld), .i_req_I(req_I), .i_req_Q(req_Q), .o_req_rdy(req_rdy),
        .o_fft_init(fft_init), .o_fft_vld(fft_vld_o), .o_fft_I(fft_I), .o_fft_Q(fft_Q),
        .i_fft_vld(core_vld), .i_fft_new_fft(core_new),
        .o_ch_id(ch_id), .o_tag_vld(tag_vld), .o_busy(busy), .o_tag_err_strb(tag_err)
`ifdef FFT_ARB_STATS_EN
        , .o_frame_cnt(frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [2*IN_W-1:0] exp_q[$];
    logic [CW-1:0]     tag_exp_q[$];
    int                frame_q[$];
    int                rem_beats [N_CH];
    bit                mon_en  = 1'b0;
    bit                tag_due = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic rand_data();
        for (int c = 0; c < N_CH; c++) begin
            req_I[c*IN_W +: IN_W] = IN_W'($urandom);
            req_Q[c*IN_W +: IN_W] = IN_W'($urandom);
        end
    endtask

    // Next channel after 'last' (cyclically) that still has beats to send.
    function automatic int rr_pick(input int last);
        for (int i = 1; i <= N_CH; i++) begin
            if (rem_beats[(last + i) % N_CH] > 0) return (last + i) % N_CH;
        end
        return -1;
    endfunction

    function automatic bit work_left(input int done, input int popped);
        int s = 0;
        for (int c = 0; c < N_CH; c++) s += rem_beats[c];
        return (s > 0) || (popped < done);
    endfunction

    // Hold 'mask' valid until n beats transfer; checks the channel of the first beat.
    task automatic run_beats(input logic [N_CH-1:0] mask, input int n, input int exp_ch);
        int got = 0;
        int guard = 0;
        logic [N_CH-1:0] hs;
        logic [N_CH-1:0] one = 1;
        while (got < n && guard < 500) begin
            @(negedge clk);
            req_vld = mask;
            rand_data();
            #1;
            hs = req_vld & req_rdy;
            if (hs != '0) begin
                if (got == 0) chk("first_grant", hs, one << exp_ch);
                got++;
            end
            guard++;
        end
        chk("beats_done", got, n);
    endtask

    task automatic pulse_new_fft();
        @(negedge clk);
        core_vld = 1'b1;
        core_new = 1'b1;
        @(negedge clk);
        core_vld = 1'b0;
        core_new = 1'b0;
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a sample or a tag.
    always @(negedge clk) begin
        if (mon_en) begin
            #2;
            if (fft_vld_o) begin
                chk("out_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("out_data", {fft_I, fft_Q}, exp_q.pop_front());
            end
            if (tag_due) begin
                chk("tag_vld", tag_vld, 1);
                if (tag_exp_q.size() != 0) chk("tag_id", ch_id, tag_exp_q.pop_front());
            end
            chk("no_tag_err", tag_err, 0);
            tag_due = core_vld && core_new;
        end else begin
            tag_due = 1'b0;
        end
    end

    initial begin
        int cur_ch, beat_idx, last_ch, done_frames, popped, cycles, ch;
        bit stall, pulse;
        logic [N_CH-1:0] hs;

        // Reset values.
        #23;
        chk("rst_fft_init", fft_init, 1);
        chk("rst_rdy", req_rdy, 0);
        chk("rst_fft_vld", fft_vld_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tag_vld", tag_vld, 0);
        chk("rst_tag_err", tag_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("init_after_rst", fft_init, 1);
        @(negedge clk);
        #1;
        chk("init_drops", fft_init, 0);

        // Tag underflow on an empty FIFO.
        pulse_new_fft();
        chk("underflow_strb", tag_err, 1);
        chk("underflow_tag_vld", tag_vld, 0);
        @(negedge clk);
        #1;
        chk("underflow_one_cycle", tag_err, 0);

        // Random multi-channel traffic against the frame-level model.
        for (int c = 0; c < N_CH; c++) rem_beats[c] = $urandom_range(1, 3) * FFT_LEN;
        cur_ch = -1; beat_idx = 0; last_ch = N_CH - 1;
        done_frames = 0; popped = 0; cycles = 0;
        mon_en = 1'b1;
        while (work_left(done_frames, popped) && cycles < 5000) begin
            @(negedge clk);
            stall = (cur_ch >= 0) && (beat_idx > 0) && ($urandom_range(0, 3) == 0);
            for (int c = 0; c < N_CH; c++)
                req_vld[c] = (rem_beats[c] > 0) && !(stall && c == cur_ch);
            rand_data();
            pulse = (done_frames > popped) && ($urandom_range(0, 2) == 0);
            core_new = pulse;
            core_vld = pulse || ($urandom_range(0, 1) == 1);
            if (pulse) begin
                tag_exp_q.push_back(CW'(frame_q.pop_front()));
                popped++;
            end
            #1;
            hs = req_vld & req_rdy;
            if (hs != '0) begin
                chk("one_hot_hs", $countones(hs), 1);
                ch = 0;
                for (int c = N_CH - 1; c >= 0; c--) if (hs[c]) ch = c;
                if (beat_idx == 0) begin
                    chk("rr_grant", ch, rr_pick(last_ch));
                    cur_ch = ch;
                    frame_q.push_back(ch);
                end else begin
                    chk("no_interleave", ch, cur_ch);
                end
                exp_q.push_back({req_I[ch*IN_W +: IN_W], req_Q[ch*IN_W +: IN_W]});
                rem_beats[ch] -= 1;
                beat_idx++;
                if (beat_idx == FFT_LEN) begin
                    beat_idx = 0;
                    last_ch = ch;
                    cur_ch = -1;
                    done_frames++;
                end
            end
            cycles++;
        end
        chk("rand_in_budget", cycles < 5000, 1);
        @(negedge clk);
        req_vld = '0; core_vld = 1'b0; core_new = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #3;
        mon_en = 1'b0;
        chk("exp_q_drained", exp_q.size(), 0);
        chk("tag_q_drained", tag_exp_q.size(), 0);

        // Abort at beat 4 of a ch0 frame; last grant must restart so ch0 wins over ch1 again.
        @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        run_beats(4'b0011, 4, 0);
        @(negedge clk);
        init = 1'b1;
        #1;
        chk("rdy_masked_in_init", req_rdy, 0);
        @(negedge clk);
        init = 1'b0;
        req_vld = '0;
        #1;
        chk("abort_fft_init", fft_init, 1);
        chk("abort_rdy", req_rdy, 0);
        chk("abort_busy", busy, 0);
        chk("abort_fft_vld", fft_vld_o, 0);
        chk("abort_tag_vld", tag_vld, 0);
        @(negedge clk);
        #1;
        chk("abort_fft_init_once", fft_init, 0);
        pulse_new_fft();
        chk("abort_fifo_empty", tag_err, 1);
        run_beats(4'b0011, FFT_LEN, 0);
        @(negedge clk);
        req_vld = '0;
        pulse_new_fft();
        chk("pop_ch0_id", ch_id, 0);
        chk("pop_ch0_vld", tag_vld, 1);

        // FIFO full: two ch2 frames without pops, then one pop releases the third grant.
        run_beats(4'b0100, 2 * FFT_LEN, 2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk("full_no_rdy", req_rdy, 0);
            chk("full_not_busy", busy, 0);
        end
        @(negedge clk);
        core_vld = 1'b1;
        core_new = 1'b1;
        @(negedge clk);
        core_vld = 1'b0;
        core_new = 1'b0;
        #1;
        chk("full_pop_id", ch_id, 2);
        chk("full_grant_cycle", req_rdy, 0);
        @(negedge clk);
        #1;
        chk("full_regrant", req_rdy, 4'b0100);
        req_vld = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
